addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the fixed 8-bit ripple adder-subtractor.
- The carry chain is split into STAGES equal chunks, with one register per chunk.
- Valid/ready handshake on both sides; full backpressure.
- Produces carry, overflow, zero and negative flags.
- Sits between the ALU operand latch and the ALU result mux.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥2.
STAGES, 2, pipeline depth and carry-chunk count; WIDTH % STAGES == 0 required (elaboration error otherwise); 1 ≤ STAGES ≤ WIDTH.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op_sub  in  1  0 = A+B+c_in, 1 = A−B−c_in (c_in acts as borrow-in)
c_in  in  1  carry/borrow in, for chaining
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
c_out  out  1  add: carry out; sub: 1 = no borrow (A ≥ B+c_in, unsigned)
ovf  out  1  signed overflow
zero  out  1  sum == 0
neg  out  1  sum[WIDTH-1]

Behaviour:
- Reset (rst = 1 at a clock edge):
  - All stage valid bits cleared; out_valid = 0.
  - sum = 0, c_out = 0, ovf = 0, zero = 0, neg = 0.
  - in_ready = 1 from the first cycle after reset.
  - In-flight beats are discarded.
  - Reset wins over any simultaneous handshake.
- Operand conditioning at input:
  - beff = b XOR {WIDTH{op_sub}}.
  - cin_eff = c_in XOR op_sub.
- Stage k (0..STAGES−1), CHUNK = WIDTH/STAGES:
  - Adds a[k·CHUNK +: CHUNK] + beff[k·CHUNK +: CHUNK] + carry from stage k−1 (stage 0 uses cin_eff).
  - Registers the partial sum and carry.
  - Upper operand slices and op_sub travel forward with the beat (skewed operand registers).
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stalls.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stage advance: stage k loads when it is empty or stage k+1 loads this cycle. Stall bubbles collapse.
  - in_ready = stage 0 empty OR stage 0 advancing.
- Output hold: while out_valid & !out_ready, sum and all flags are held stable.
- Flags from the final stage:
  - c_out = carry out of the top chunk.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - neg = sum[WIDTH−1].
- Wrap-around: sum is modulo 2^WIDTH; no exceptions.
- STAGES = 1: single register stage, latency 1.
- Simultaneous accept and emit: in the same cycle with a full pipeline, no bubble is inserted.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined:
  - Extra input port sat (1 bit), captured with the beat.
  - When sat = 1 and ovf = 1, sum is clamped:
    - positive overflow (inputs non-negative) → 0111…1;
    - negative overflow → 1000…0.
  - Flags zero and neg reflect the clamped sum; ovf still reports 1.
- Undefined: no sat port; sum always wraps.

Decomposition:
- Package addsub_pkg:
  - typedef for the flag bundle {c_out, ovf, zero, neg};
  - localparam function for CHUNK;
  - op encoding constants OP_ADD = 0, OP_SUB = 1.
- Sub-module addsub_stage:
  - one chunk adder plus its pipeline register and valid/stall logic;
  - instantiated STAGES times via generate.
- Top level: conditioning, flag generation, saturation.

Test Plan:
All scenarios use WIDTH = 8, STAGES = 2 unless stated.
- Add: a = 13, b = 7, op_sub = 0, c_in = 0 → after 2 cycles sum = 20, c_out = 0, ovf = 0, zero = 0, neg = 0.
- Subtract: a = 64, b = 32, op_sub = 1, c_in = 0 → sum = 32, c_out = 1. Also a = 0, b = 1, op_sub = 1 → sum = 255, c_out = 0, neg = 1.
- Overflow and zero: a = 127, b = 1, add → sum = 128, ovf = 1, neg = 1. Also a = 255, b = 1 → sum = 0, c_out = 1, zero = 1. With ADDSUB_SAT_EN and sat = 1, the 127+1 case → sum = 127, ovf = 1.
- Backpressure: stream 4 beats with out_ready = 0 for 5 cycles, then 1.
  - in_ready drops after 2 accepted beats.
  - Output held stable while stalled.
  - All 4 results appear in order, with no loss or duplication.
- Reset mid-operation: assert rst with 2 beats in flight → next cycle out_valid = 0, all outputs 0, in_ready = 1; the old beats never appear.
- Parameter sweep: WIDTH = 16 with STAGES = 1, 4 and 16; 1000 random beats with random out_ready → results match a reference model, and latency equals STAGES when unstalled.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// Optional saturation is enabled elsewhere with the ADDSUB_SAT_EN macro.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  function automatic int chunkWidth(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The sat member exists only when ADDSUB_SAT_EN is defined.
interface addsub_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             c_in;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
`ifdef ADDSUB_SAT_EN
    output sat,
`endif
    output in_valid, a, b, op_sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero, neg
  );

  modport slave (
`ifdef ADDSUB_SAT_EN
    input  sat,
`endif
    input  in_valid, a, b, op_sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero, neg
  );

endinterface

// File: rtl/addsub_stage.sv
// One carry-chunk of the pipeline: adds slice IDX of the skewed operands
// and registers the beat, loading when empty or when the next stage loads.
module addsub_stage #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_carry,
  input  logic             i_sat,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_sat
);

  logic             w_load;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum;

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sat;

  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;

  assign w_chunk = {1'b0, i_a[IDX*CHUNK +: CHUNK]}
                 + {1'b0, i_b[IDX*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_carry};

  always_comb begin
    w_sum = i_sum;
    w_sum[IDX*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // Data registers only move with a real beat so a stalled or drained
  // output keeps presenting the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_sum   <= w_sum;
        r_carry <= w_chunk[CHUNK];
        r_sat   <= i_sat;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;
  assign o_sat   = r_sat;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, STAGES carry chunks deep.
// Define ADDSUB_SAT_EN to add the sat input and clamp on signed overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  addsub_if.slave  bus
);

  localparam int CHUNK = chunkWidth(WIDTH, STAGES);

  if ((WIDTH < 2) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_badParams
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             w_isSub;
  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic [WIDTH-1:0] w_a     [STAGES+1];
  logic [WIDTH-1:0] w_b     [STAGES+1];
  logic [WIDTH-1:0] w_sum   [STAGES+1];
  logic             w_carry [STAGES+1];
  logic             w_sat   [STAGES+1];
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  flags_t           w_flags;

  // Subtraction is A + ~B + ~c_in, so c_in becomes a borrow-in.
  assign w_isSub     = (bus.op_sub == OP_SUB);
  assign w_valid[0]  = bus.in_valid;
  assign w_a[0]      = bus.a;
  assign w_b[0]      = bus.b ^ {WIDTH{w_isSub}};
  assign w_sum[0]    = '0;
  assign w_carry[0]  = bus.c_in ^ w_isSub;
`ifdef ADDSUB_SAT_EN
  assign w_sat[0]    = bus.sat;
`else
  assign w_sat[0]    = 1'b0;
`endif
  assign w_ready[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_ready (w_ready[k+1]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .i_sum   (w_sum[k]),
      .i_carry (w_carry[k]),
      .i_sat   (w_sat[k]),
      .o_valid (w_valid[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1]),
      .o_sum   (w_sum[k+1]),
      .o_carry (w_carry[k+1]),
      .o_sat   (w_sat[k+1])
    );
  end

  // Carry into the MSB is recovered as sum ^ a ^ beff at that bit.
  always_comb begin
    w_ovf    = w_sum[STAGES][WIDTH-1] ^ w_a[STAGES][WIDTH-1]
             ^ w_b[STAGES][WIDTH-1] ^ w_carry[STAGES];
    w_result = w_sum[STAGES];
`ifdef ADDSUB_SAT_EN
    if (w_sat[STAGES] && w_ovf) begin
      w_result = w_a[STAGES][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    w_flags.c_out = w_carry[STAGES];
    w_flags.ovf   = w_ovf;
    w_flags.zero  = w_valid[STAGES] && (w_result == '0);
    w_flags.neg   = w_result[WIDTH-1];
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.out_valid = w_valid[STAGES];
  assign bus.sum       = w_result;
  assign bus.c_out     = w_flags.c_out;
  assign bus.ovf       = w_flags.ovf;
  assign bus.zero      = w_flags.zero;
  assign bus.neg       = w_flags.neg;

endmodule
